// File: rtl/pipeline_pkg.sv
// Shared definitions for the late-ALU issue/collect controller:
// opcodes, the result entry carried through the FIFO, and op legality.
package pipeline_pkg;

    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    // One returned result: destination, illegal-op flag and value.
    typedef struct packed {
        logic [4:0]  rd;
        logic        err;
        logic [31:0] data;
    } result_t;

    // Only the two shift functions are executed by the late ALU.
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/pipeline_latealu_fifo.sv
// Circular result FIFO for the late-ALU controller.
// Push and pop may coincide; the head entry is always presented on 'head'.
module pipeline_latealu_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  result_t          push_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output result_t          head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    result_t          mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Qualify requests so an empty pop or a full push never corrupts state.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_CNT) || do_pop);
        head    = mem[head_ptr];
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[tail_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= next_ptr(tail_ptr);
            end
            if (do_pop) begin
                head_ptr <= next_ptr(head_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_latealu_ctrl.sv
// Issue/collect controller for the late-ALU shift unit. Requests are issued
// straight to the ALU, the registered ALU result is captured one cycle later
// and returned to writeback either by bypass or through the result FIFO.
module pipeline_latealu_ctrl
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_a1,
    input  logic [4:0]  req_rd,
    output logic [5:0]  alu_op,
    output logic [31:0] alu_a0,
    output logic [31:0] alu_a1,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic [31:0] pending
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    result_t          head;
    result_t          resolved;
    result_t          wb_entry;
    logic             inflight;
    logic [4:0]       if_rd;
    logic             if_err;
    logic [31:0]      pending_q;
    logic [31:0]      pending_next;
    logic             legal;
    logic             acc;
    logic             fifo_empty;
    logic             bypass_take;
    logic             push;
    logic             pop;
    logic             wb_hs;

    // Admission: room for one more result and no outstanding write to req_rd.
    always_comb begin
        legal     = is_legal_op(req_op);
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        req_ready = rst && (occupancy < DEPTH_LIMIT)
                    && ((req_rd == 5'd0) || !pending_q[req_rd]);
        acc       = req_valid && req_ready;
        alu_op    = (acc && legal) ? req_op : 6'd0;
        alu_a0    = (acc && legal) ? req_a0 : 32'd0;
        alu_a1    = (acc && legal) ? req_a1 : 32'd0;
    end

    // Writeback selection: FIFO head first, else bypass the resolving slot.
    always_comb begin
        fifo_empty    = (count == '0);
        resolved.rd   = if_rd;
        resolved.err  = if_err;
        resolved.data = if_err ? 32'd0 : alu_result;
        wb_entry      = '0;
        wb_valid      = 1'b0;
        if (rst) begin
            if (!fifo_empty) begin
                wb_valid = 1'b1;
                wb_entry = head;
            end else if (inflight) begin
                wb_valid = 1'b1;
                wb_entry = resolved;
            end
        end
        wb_rd       = wb_entry.rd;
        wb_data     = wb_entry.data;
        wb_err      = wb_entry.err;
        wb_hs       = wb_valid && wb_ready;
        bypass_take = rst && fifo_empty && inflight && wb_ready;
        push        = rst && inflight && !bypass_take;
        pop         = rst && !fifo_empty && wb_ready;
    end

    // Pending mask: set on accept, clear on retire; r0 is never tracked.
    always_comb begin
        pending_next = pending_q;
        if (wb_hs) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (acc && (req_rd != 5'd0)) begin
            pending_next[req_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
        pending         = pending_q;
    end

    // In-flight slot and pending register, both cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight  <= 1'b0;
            if_rd     <= 5'd0;
            if_err    <= 1'b0;
            pending_q <= 32'd0;
        end else begin
            inflight  <= acc;
            pending_q <= pending_next;
            if (acc) begin
                if_rd  <= req_rd;
                if_err <= !legal;
            end
        end
    end

    pipeline_latealu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (resolved),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

endmodule

// File: tb/tb_pipeline_latealu_ctrl.sv
// Directed bench for pipeline_latealu_ctrl with a behavioural late ALU.
module tb_pipeline_latealu_ctrl;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [4:0]  req_rd;
    logic [5:0]  alu_op;
    logic [31:0] alu_a0;
    logic [31:0] alu_a1;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    pipeline_latealu_ctrl #(
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_rd     (req_rd),
        .alu_op     (alu_op),
        .alu_a0     (alu_a0),
        .alu_a1     (alu_a1),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_err     (wb_err),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Late ALU: registered result, op 0 (or anything else) holds the value.
    always @(posedge clk) begin
        case (alu_op)
            OP_SRL:  alu_result <= alu_a0 >> alu_a1[4:0];
            OP_SRA:  alu_result <= $signed(alu_a0) >>> alu_a1[4:0];
            default: alu_result <= alu_result;
        endcase
    end

    task automatic apply_stimulus(input logic valid, input logic [5:0] op,
                                  input logic [31:0] a0, input logic [31:0] a1,
                                  input logic [4:0] rd, input logic ready);
        req_valid = valid;
        req_op    = op;
        req_a0    = a0;
        req_a1    = a1;
        req_rd    = rd;
        wb_ready  = ready;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ready);
        apply_stimulus(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, ready);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with a legal request already presented
        rst = 1'b0;
        apply_stimulus(1'b1, OP_SRL, 32'h0000_1234, 32'd4, 5'd3, 1'b1);
        @(negedge clk);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_output("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_output("rst_wb_data", wb_data, 32'd0);
        check_output("rst_wb_err", 32'(wb_err), 32'd0);
        check_output("rst_alu_op", 32'(alu_op), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("rst_pending", pending, 32'd0);

        next_cycle();
        rst = 1'b1;
        idle(1'b1);
        @(negedge clk);
        check_output("post_rst_ready", 32'(req_ready), 32'd1);
        check_output("post_rst_wb_valid", 32'(wb_valid), 32'd0);

        // Single srl with bypass
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'hF000_0000, 32'd4, 5'd5, 1'b1);
        @(negedge clk);
        check_output("srl_ready", 32'(req_ready), 32'd1);
        check_output("srl_alu_op", 32'(alu_op), 32'(OP_SRL));
        check_output("srl_alu_a0", alu_a0, 32'hF000_0000);
        check_output("srl_alu_a1", alu_a1, 32'd4);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_output("srl_wb_valid", 32'(wb_valid), 32'd1);
        check_output("srl_wb_data", wb_data, 32'h0F00_0000);
        check_output("srl_wb_rd", 32'(wb_rd), 32'd5);
        check_output("srl_wb_err", 32'(wb_err), 32'd0);
        check_output("srl_pending", pending, 32'h0000_0020);
        next_cycle();
        @(negedge clk);
        check_output("srl_retired_valid", 32'(wb_valid), 32'd0);
        check_output("srl_retired_pending", pending, 32'd0);

        // sra uses only a1[4:0]
        next_cycle();
        apply_stimulus(1'b1, OP_SRA, 32'h8000_0000, 32'h0000_0024, 5'd6, 1'b1);
        @(negedge clk);
        check_output("sra_alu_op", 32'(alu_op), 32'(OP_SRA));
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_output("sra_wb_data", wb_data, 32'hF800_0000);
        check_output("sra_wb_rd", 32'(wb_rd), 32'd6);

        // Illegal op: no ALU drive, error result with zero data
        next_cycle();
        apply_stimulus(1'b1, 6'b100000, 32'h0000_1234, 32'd1, 5'd8, 1'b1);
        @(negedge clk);
        check_output("ill_ready", 32'(req_ready), 32'd1);
        check_output("ill_alu_op", 32'(alu_op), 32'd0);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_output("ill_wb_valid", 32'(wb_valid), 32'd1);
        check_output("ill_wb_err", 32'(wb_err), 32'd1);
        check_output("ill_wb_data", wb_data, 32'd0);
        check_output("ill_wb_rd", 32'(wb_rd), 32'd8);
        check_output("ill_pending", pending, 32'h0000_0100);
        next_cycle();
        @(negedge clk);
        check_output("ill_retired_pending", pending, 32'd0);

        // Backpressure with DEPTH 2
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0100, 32'd4, 5'd1, 1'b0);
        @(negedge clk);
        check_output("bp_c0_ready", 32'(req_ready), 32'd1);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0200, 32'd4, 5'd2, 1'b0);
        @(negedge clk);
        check_output("bp_c1_ready", 32'(req_ready), 32'd1);
        check_output("bp_c1_wb_rd", 32'(wb_rd), 32'd1);
        check_output("bp_c1_wb_data", wb_data, 32'h0000_0010);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0300, 32'd4, 5'd3, 1'b0);
        @(negedge clk);
        check_output("bp_c2_ready", 32'(req_ready), 32'd0);
        check_output("bp_c2_alu_op", 32'(alu_op), 32'd0);
        check_output("bp_c2_wb_rd", 32'(wb_rd), 32'd1);
        check_output("bp_c2_wb_data", wb_data, 32'h0000_0010);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0300, 32'd4, 5'd3, 1'b1);
        @(negedge clk);
        check_output("bp_c3_ready", 32'(req_ready), 32'd0);
        check_output("bp_c3_pending", pending, 32'h0000_0006);
        check_output("bp_c3_wb_rd", 32'(wb_rd), 32'd1);
        check_output("bp_c3_wb_data", wb_data, 32'h0000_0010);
        next_cycle();
        @(negedge clk);
        check_output("bp_c4_ready", 32'(req_ready), 32'd1);
        check_output("bp_c4_wb_rd", 32'(wb_rd), 32'd2);
        check_output("bp_c4_wb_data", wb_data, 32'h0000_0020);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_output("bp_c5_wb_rd", 32'(wb_rd), 32'd3);
        check_output("bp_c5_wb_data", wb_data, 32'h0000_0030);
        next_cycle();
        @(negedge clk);
        check_output("bp_drained_valid", 32'(wb_valid), 32'd0);
        check_output("bp_drained_pending", pending, 32'd0);

        // RAW interlock on r7
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0070, 32'd0, 5'd7, 1'b0);
        @(negedge clk);
        check_output("raw_c0_ready", 32'(req_ready), 32'd1);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0080, 32'd0, 5'd7, 1'b0);
        @(negedge clk);
        check_output("raw_c1_ready", 32'(req_ready), 32'd0);
        check_output("raw_c1_pending", pending, 32'h0000_0080);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0080, 32'd0, 5'd7, 1'b1);
        @(negedge clk);
        check_output("raw_c2_ready", 32'(req_ready), 32'd0);
        check_output("raw_c2_wb_data", wb_data, 32'h0000_0070);
        next_cycle();
        @(negedge clk);
        check_output("raw_c3_ready", 32'(req_ready), 32'd1);
        check_output("raw_c3_pending", pending, 32'd0);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_output("raw_c4_wb_rd", 32'(wb_rd), 32'd7);
        check_output("raw_c4_wb_data", wb_data, 32'h0000_0080);

        // Destination r0 is never interlocked
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_00A0, 32'd4, 5'd0, 1'b1);
        @(negedge clk);
        check_output("r0_c0_ready", 32'(req_ready), 32'd1);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_00B0, 32'd4, 5'd0, 1'b1);
        @(negedge clk);
        check_output("r0_c1_ready", 32'(req_ready), 32'd1);
        check_output("r0_c1_pending", pending, 32'd0);
        check_output("r0_c1_wb_data", wb_data, 32'h0000_000A);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_output("r0_c2_wb_data", wb_data, 32'h0000_000B);
        check_output("r0_c2_pending", pending, 32'd0);

        // Reset with one FIFO entry and one in-flight result
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0100, 32'd4, 5'd1, 1'b0);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'h0000_0200, 32'd4, 5'd2, 1'b0);
        next_cycle();
        rst = 1'b0;
        idle(1'b0);
        @(negedge clk);
        check_output("mrst_c2_wb_valid", 32'(wb_valid), 32'd0);
        check_output("mrst_c2_ready", 32'(req_ready), 32'd0);
        check_output("mrst_c2_wb_data", wb_data, 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("mrst_c3_wb_valid", 32'(wb_valid), 32'd0);
        check_output("mrst_c3_pending", pending, 32'd0);
        check_output("mrst_c3_ready", 32'(req_ready), 32'd0);
        next_cycle();
        rst = 1'b1;
        idle(1'b1);
        @(negedge clk);
        check_output("mrst_rel_ready", 32'(req_ready), 32'd1);
        check_output("mrst_rel_wb_valid", 32'(wb_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_output("mrst_no_stale", 32'(wb_valid), 32'd0);
        next_cycle();
        apply_stimulus(1'b1, OP_SRL, 32'hFFFF_FFFF, 32'd31, 5'd9, 1'b1);
        next_cycle();
        idle(1'b1);
        @(negedge clk);
        check_output("mrst_after_wb_data", wb_data, 32'd1);
        check_output("mrst_after_wb_rd", 32'(wb_rd), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
